// File: rtl/id_stage.sv
// RV32I instruction decode stage: IF/ID holding register, combinational
// decode with write-back bypass, load-use hazard detection and a
// registered ID/EX bundle handed to execute under valid/ready.
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_instr,
  output logic [4:0]      raddr1,
  output logic [4:0]      raddr2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [2:0]      id_funct3,
  output logic [3:0]      id_alu_op,
  output logic            id_alu_src_imm,
  output logic            id_regwrite,
  output logic            id_memread,
  output logic            id_memwrite,
  output logic            id_branch,
  output logic            id_jump,
  output logic            id_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic            ifid_valid;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_instr;

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [XLEN-1:0] dec_imm;
  logic [3:0]      dec_alu_op;
  logic            dec_src_imm, dec_regwrite, dec_memread, dec_memwrite;
  logic            dec_branch, dec_jump, dec_illegal, rs1_used, rs2_used;
  logic [XLEN-1:0] op1, op2;
  logic            hazard, out_load, fire;

  assign opcode = ifid_instr[6:0];
  assign rd     = ifid_instr[11:7];
  assign funct3 = ifid_instr[14:12];
  assign rs1    = ifid_instr[19:15];
  assign rs2    = ifid_instr[24:20];
  assign raddr1 = rs1;
  assign raddr2 = rs2;

  assign imm_i = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
  assign imm_s = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
  assign imm_b = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                  ifid_instr[30:25], ifid_instr[11:8], 1'b0};
  assign imm_u = {ifid_instr[31:12], 12'b0};
  assign imm_j = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                  ifid_instr[20], ifid_instr[30:21], 1'b0};

  // Opcode decode into control bits, immediate and operand usage
  always_comb begin
    dec_imm      = '0;
    dec_alu_op   = 4'b0000;
    dec_src_imm  = 1'b0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_branch   = 1'b0;
    dec_jump     = 1'b0;
    dec_illegal  = 1'b0;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_imm = imm_u; dec_src_imm = 1'b1; dec_regwrite = 1'b1;
      end
      OPC_JAL: begin
        dec_imm = imm_j; dec_src_imm = 1'b1; dec_regwrite = 1'b1; dec_jump = 1'b1;
      end
      OPC_JALR: begin
        dec_imm = imm_i; dec_src_imm = 1'b1; dec_regwrite = 1'b1; dec_jump = 1'b1;
        rs1_used = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm = imm_b; dec_branch = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OPC_LOAD: begin
        dec_imm = imm_i; dec_src_imm = 1'b1; dec_regwrite = 1'b1; dec_memread = 1'b1;
        rs1_used = 1'b1;
      end
      OPC_STORE: begin
        dec_imm = imm_s; dec_src_imm = 1'b1; dec_memwrite = 1'b1;
        rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OPC_OPIMM: begin
        dec_imm = imm_i; dec_src_imm = 1'b1; dec_regwrite = 1'b1; rs1_used = 1'b1;
        if (funct3 == 3'b101) dec_alu_op = {ifid_instr[30], 3'b101};
      end
      OPC_OP: begin
        dec_regwrite = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        dec_alu_op = {ifid_instr[30], funct3};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Operand select: x0 reads zero, a same-cycle write-back wins over the file
  always_comb begin
    if (rs1 == 5'd0)                           op1 = '0;
    else if (wb_regwrite && wb_waddr == rs1)   op1 = wb_wdata;
    else                                       op1 = rdata1;
    if (rs2 == 5'd0)                           op2 = '0;
    else if (wb_regwrite && wb_waddr == rs2)   op2 = wb_wdata;
    else                                       op2 = rdata2;
  end

  assign hazard   = ex_memread && (ex_rd != 5'd0) &&
                    ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));
  assign out_load = !id_valid || id_ready;
  assign fire     = ifid_valid && out_load && !hazard;
  assign if_ready = !ifid_valid || fire || flush;

  // IF/ID holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
    end else if (if_valid && if_ready) begin
      ifid_valid <= 1'b1;
      ifid_pc    <= if_pc;
      ifid_instr <= if_instr;
    end else if (fire) begin
      ifid_valid <= 1'b0;
    end
  end

  // ID/EX bundle register; contents hold while a bubble is presented
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_rs1_val     <= '0;
      id_rs2_val     <= '0;
      id_imm         <= '0;
      id_rs1         <= '0;
      id_rs2         <= '0;
      id_rd          <= '0;
      id_funct3      <= '0;
      id_alu_op      <= '0;
      id_alu_src_imm <= 1'b0;
      id_regwrite    <= 1'b0;
      id_memread     <= 1'b0;
      id_memwrite    <= 1'b0;
      id_branch      <= 1'b0;
      id_jump        <= 1'b0;
      id_illegal     <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (fire) begin
      id_valid       <= 1'b1;
      id_pc          <= ifid_pc;
      id_rs1_val     <= op1;
      id_rs2_val     <= op2;
      id_imm         <= dec_imm;
      id_rs1         <= rs1;
      id_rs2         <= rs2;
      id_rd          <= rd;
      id_funct3      <= funct3;
      id_alu_op      <= dec_alu_op;
      id_alu_src_imm <= dec_src_imm;
      id_regwrite    <= dec_regwrite;
      id_memread     <= dec_memread;
      id_memwrite    <= dec_memwrite;
      id_branch      <= dec_branch;
      id_jump        <= dec_jump;
      id_illegal     <= dec_illegal;
    end else if (out_load) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by a randomized run, all
// checked every cycle against a transaction-level model of the stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, if_valid, if_ready;
  logic [31:0] if_pc, if_instr, rdata1, rdata2, wb_wdata;
  logic [4:0]  raddr1, raddr2, wb_waddr, ex_rd;
  logic        wb_regwrite, ex_memread, flush, id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_imm, id_regwrite, id_memread, id_memwrite;
  logic        id_branch, id_jump, id_illegal;

  logic [31:0] regs [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  id_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .wb_regwrite(wb_regwrite),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_alu_op(id_alu_op),
    .id_alu_src_imm(id_alu_src_imm), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_jump(id_jump), .id_illegal(id_illegal)
  );

  typedef struct {
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic src, rw, mr, mw, br, jp, ill, use1, use2;
  } dec_t;

  typedef struct {
    logic [31:0] pc, v1, v2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu_op;
    logic src, rw, mr, mw, br, jp, ill;
  } bun_t;

  logic        m_ifid_v, m_id_v;
  logic [31:0] m_ifid_pc, m_ifid_instr;
  bun_t        m_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: immediates built arithmetically from the sign of the word
  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d;
    logic signed [31:0] s;
    logic [31:0] sgn, hi20, hi25;
    s    = i;
    sgn  = s >>> 31;
    hi20 = s >>> 20;
    hi25 = s >>> 25;
    d = '{default: '0};
    case (i[6:0])
      7'h37, 7'h17: begin d.imm = i & 32'hFFFF_F000; d.rw = 1; d.src = 1; end
      7'h6F: begin
        d.imm = (sgn << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        d.rw = 1; d.jp = 1; d.src = 1;
      end
      7'h67: begin d.imm = hi20; d.rw = 1; d.jp = 1; d.src = 1; d.use1 = 1; end
      7'h63: begin
        d.imm = (sgn << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        d.br = 1; d.use1 = 1; d.use2 = 1;
      end
      7'h03: begin d.imm = hi20; d.rw = 1; d.mr = 1; d.src = 1; d.use1 = 1; end
      7'h23: begin
        d.imm = (hi25 << 5) | 32'(i[11:7]);
        d.mw = 1; d.src = 1; d.use1 = 1; d.use2 = 1;
      end
      7'h13: begin
        d.imm = hi20; d.rw = 1; d.src = 1; d.use1 = 1;
        if (i[14:12] == 3'd5) d.alu_op = {i[30], 3'd5};
      end
      7'h33: begin d.rw = 1; d.use1 = 1; d.use2 = 1; d.alu_op = {i[30], i[14:12]}; end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_regwrite && wb_waddr == r) return wb_wdata;
    return regs[r];
  endfunction

  // One clock: check DUT against the model, then advance the model
  task automatic step();
    dec_t d;
    logic [4:0] r1, r2;
    logic hz, ol, fi, rdy;
    bun_t nb;
    #1;
    r1 = m_ifid_instr[19:15];
    r2 = m_ifid_instr[24:20];
    d  = ref_decode(m_ifid_instr);
    hz = ex_memread && ex_rd != 0 && ((d.use1 && ex_rd == r1) || (d.use2 && ex_rd == r2));
    ol = !m_id_v || id_ready;
    fi = m_ifid_v && ol && !hz;
    rdy = !m_ifid_v || fi || flush;
    chk("if_ready", 32'(if_ready), 32'(rdy));
    if (m_ifid_v) begin
      chk("raddr1", 32'(raddr1), 32'(r1));
      chk("raddr2", 32'(raddr2), 32'(r2));
    end
    chk("id_valid", 32'(id_valid), 32'(m_id_v));
    chk("id_pc", id_pc, m_b.pc);
    chk("id_rs1_val", id_rs1_val, m_b.v1);
    chk("id_rs2_val", id_rs2_val, m_b.v2);
    chk("id_imm", id_imm, m_b.imm);
    chk("id_regs", {17'd0, id_rs1, id_rs2, id_rd}, {17'd0, m_b.rs1, m_b.rs2, m_b.rd});
    chk("id_funct3", 32'(id_funct3), 32'(m_b.f3));
    chk("id_alu_op", 32'(id_alu_op), 32'(m_b.alu_op));
    chk("id_ctrl", {25'd0, id_alu_src_imm, id_regwrite, id_memread, id_memwrite,
                    id_branch, id_jump, id_illegal},
                   {25'd0, m_b.src, m_b.rw, m_b.mr, m_b.mw, m_b.br, m_b.jp, m_b.ill});
    nb = '{pc: m_ifid_pc, v1: operand(r1), v2: operand(r2), imm: d.imm, rs1: r1, rs2: r2,
           rd: m_ifid_instr[11:7], f3: m_ifid_instr[14:12], alu_op: d.alu_op,
           src: d.src, rw: d.rw, mr: d.mr, mw: d.mw, br: d.br, jp: d.jp, ill: d.ill};
    @(posedge clk);
    if (reset) begin
      m_ifid_v = 0; m_ifid_pc = 0; m_ifid_instr = 0; m_id_v = 0; m_b = '{default: '0};
    end else if (flush) begin
      m_ifid_v = 0; m_id_v = 0;
    end else begin
      if (fi) begin m_b = nb; m_id_v = 1; end
      else if (ol) m_id_v = 0;
      if (if_valid && rdy) begin m_ifid_v = 1; m_ifid_pc = if_pc; m_ifid_instr = if_instr; end
      else if (fi) m_ifid_v = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; if_valid = 0; if_pc = 0; if_instr = 0; wb_regwrite = 0; wb_waddr = 0;
    wb_wdata = 0; ex_memread = 0; ex_rd = 0; flush = 0; id_ready = 1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1; if_pc = pc; if_instr = instr;
    step();
    if_valid = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] opcs [10];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
    r = $urandom;
    r[6:0]   = opcs[$urandom_range(0, 9)];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_ifid_v = 0; m_ifid_pc = 0; m_ifid_instr = 0; m_id_v = 0; m_b = '{default: '0};
    #1;
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_imm", id_imm, 32'd0);
    reset = 0;
    step();

    // addi x1,x0,5 streams through in one cycle
    offer(32'h0, 32'h0050_0093);
    step();
    chk("addi_valid", 32'(id_valid), 32'd1);
    chk("addi_imm", id_imm, 32'd5);
    chk("addi_rd", 32'(id_rd), 32'd1);
    chk("addi_ctl", {30'd0, id_regwrite, id_alu_src_imm}, 32'd3);
    chk("addi_aluop", 32'(id_alu_op), 32'd0);

    // load-use: add x3,x1,x2 behind a load to x1
    offer(32'h4, 32'h0020_81B3);
    ex_memread = 1; ex_rd = 1;
    #1 chk("lu_if_ready", 32'(if_ready), 32'd0);
    step();
    chk("lu_bubble", 32'(id_valid), 32'd0);
    ex_memread = 0; ex_rd = 0;
    step();
    chk("lu_issue", 32'(id_valid), 32'd1);
    chk("lu_rd", 32'(id_rd), 32'd3);

    // same-cycle bypass, and x0 never bypassed
    regs[5] = 32'h11; regs[0] = 32'h11;
    offer(32'h8, 32'h0002_8393);
    wb_regwrite = 1; wb_waddr = 5; wb_wdata = 32'hABCD;
    step();
    chk("byp_rs1", id_rs1_val, 32'hABCD);
    offer(32'hC, 32'h0000_0393);
    wb_waddr = 0;
    step();
    chk("byp_x0", id_rs1_val, 32'd0);
    wb_regwrite = 0;

    // back-pressure with two instructions queued
    id_ready = 0;
    offer(32'h10, 32'h0010_0113);
    if_valid = 1; if_pc = 32'h14; if_instr = 32'h0020_0193;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_pc", id_pc, 32'hC);
      chk("bp_if_ready", 32'(if_ready), 32'd0);
    end
    id_ready = 1;
    step();
    if_valid = 0;
    chk("bp_first", id_pc, 32'h10);
    step();
    chk("bp_second", id_pc, 32'h14);
    step();
    chk("bp_drain", 32'(id_valid), 32'd0);

    // flush with both registers full; offered instruction is dropped
    offer(32'h18, 32'h0030_0213);
    id_ready = 0;
    offer(32'h1C, 32'h0040_0293);
    flush = 1;
    offer(32'h20, 32'h0050_0313);
    flush = 0; id_ready = 1;
    chk("fl_id_valid", 32'(id_valid), 32'd0);
    chk("fl_if_ready", 32'(if_ready), 32'd1);
    step();
    chk("fl_discard", 32'(id_valid), 32'd0);

    // B-immediate and illegal opcode
    offer(32'h24, 32'hFE00_0EE3);
    step();
    chk("beq_imm", id_imm, 32'hFFFF_FFFC);
    chk("beq_branch", 32'(id_branch), 32'd1);
    offer(32'h28, 32'h0000_007F);
    step();
    chk("ill_flag", 32'(id_illegal), 32'd1);
    chk("ill_ctl", {27'd0, id_regwrite, id_memread, id_memwrite, id_branch, id_jump}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      if_valid    = ($urandom_range(0, 3) != 0);
      if_pc       = $urandom & 32'hFFFF_FFFC;
      if_instr    = rand_instr();
      id_ready    = ($urandom_range(0, 3) != 0);
      ex_memread  = ($urandom_range(0, 3) == 0);
      ex_rd       = 5'($urandom_range(0, 3));
      wb_regwrite = $urandom_range(0, 1) == 1;
      wb_waddr    = 5'($urandom_range(0, 3));
      wb_wdata    = $urandom;
      if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 3)] = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
